// File: rtl/io_pad_pkg.sv
// Shared types and reset constants for the bidirectional pad-bank controller.
package io_pad_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      TURN  = 2'd2,
      RX    = 2'd3
   } pad_state_e;

   typedef enum logic {
      DIR_RX   = 1'b0,
      DIR_IDLE = 1'b1
   } turn_dir_e;

   localparam logic [1:0] PAD_DS_RST = 2'b01;
   localparam logic       PAD_SR_RST = 1'b0;

endpackage

// File: rtl/io_pad_sync.sv
// Multi-flop synchronizer for asynchronous pad inputs; SYNC_STAGES cycles latency, no backpressure.
module io_pad_sync #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [SYNC_STAGES];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/io_pad_bidir_ctrl.sv
// Registered OE/IE/A/DS/SR control for a pad bank with TURN_CYCLES dead cycles per turnaround; rx_valid
// 1+TURN_CYCLES+SYNC_STAGES cycles after rx_en, tx_ready low outside IDLE/DRIVE. Option: PAD_LOOPBACK_CHECK_EN.
module io_pad_bidir_ctrl
   import io_pad_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int TURN_CYCLES = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [1:0]       cfg_ds,
   input  logic             cfg_sr,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             rx_en,
   output logic             rx_valid,
   output logic [WIDTH-1:0] rx_data,
   output logic             err_mismatch,
   output logic [WIDTH-1:0] pad_a,
   output logic             pad_oe,
   output logic             pad_ie,
   output logic             pad_ds0,
   output logic             pad_ds1,
   output logic             pad_sr,
   input  logic [WIDTH-1:0] pad_y
);

   localparam int TCW = $clog2(TURN_CYCLES + 1);
   localparam int RCW = $clog2(SYNC_STAGES);
   localparam logic [TCW-1:0] TURN_LAST = TCW'(TURN_CYCLES - 1);
   localparam logic [RCW-1:0] RX_LAST   = RCW'(SYNC_STAGES - 1);
`ifdef PAD_LOOPBACK_CHECK_EN
   localparam logic IE_IN_DRIVE = 1'b1;
`else
   localparam logic IE_IN_DRIVE = 1'b0;
`endif

   pad_state_e       state_q, state_d;
   turn_dir_e        dir_q, dir_d;
   logic [TCW-1:0]   turn_cnt_q, turn_cnt_d;
   logic [RCW-1:0]   rx_cnt_q, rx_cnt_d;
   logic [WIDTH-1:0] pad_a_q, pad_a_d;
   logic [1:0]       ds_q, ds_d;
   logic             sr_q, sr_d;
   logic             oe_q, oe_d;
   logic             ie_q, ie_d;
   logic             tx_ready_q, tx_ready_d;
   logic             rx_valid_q, rx_valid_d;
   logic             tx_acc;
   logic [WIDTH-1:0] sync_y;

   io_pad_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rstn (rstn),
      .d_i  (pad_y),
      .q_o  (sync_y)
   );

   assign tx_acc = tx_valid && tx_ready_q;

   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      turn_cnt_d = turn_cnt_q;
      rx_cnt_d   = rx_cnt_q;
      pad_a_d    = pad_a_q;
      ds_d       = ds_q;
      sr_d       = sr_q;
      oe_d       = oe_q;
      ie_d       = ie_q;
      rx_valid_d = rx_valid_q;
      case (state_q)
         IDLE: begin
            ds_d = cfg_ds;
            sr_d = cfg_sr;
            // A pending word blocks the RX request even before tx_ready rises after reset.
            if (tx_acc) begin
               pad_a_d = tx_data;
               oe_d    = 1'b1;
               ie_d    = IE_IN_DRIVE;
               state_d = DRIVE;
            end else if (!tx_valid && rx_en) begin
               state_d    = TURN;
               dir_d      = DIR_RX;
               turn_cnt_d = '0;
            end
         end
         DRIVE: begin
            if (tx_acc) begin
               pad_a_d = tx_data;
            end else if (rx_en) begin
               oe_d       = 1'b0;
               ie_d       = 1'b0;
               state_d    = TURN;
               dir_d      = DIR_RX;
               turn_cnt_d = '0;
            end
         end
         TURN: begin
            if (turn_cnt_q == TURN_LAST) begin
               if (dir_q == DIR_RX) begin
                  state_d  = RX;
                  ie_d     = 1'b1;
                  rx_cnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               turn_cnt_d = turn_cnt_q + 1'b1;
            end
         end
         RX: begin
            if (!rx_en) begin
               ie_d       = 1'b0;
               rx_valid_d = 1'b0;
               state_d    = TURN;
               dir_d      = DIR_IDLE;
               turn_cnt_d = '0;
            end else if (rx_cnt_q == RX_LAST) begin
               rx_valid_d = 1'b1;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      tx_ready_d = (state_d == IDLE) || (state_d == DRIVE);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= IDLE;
         dir_q      <= DIR_IDLE;
         turn_cnt_q <= '0;
         rx_cnt_q   <= '0;
         pad_a_q    <= '0;
         ds_q       <= PAD_DS_RST;
         sr_q       <= PAD_SR_RST;
         oe_q       <= 1'b0;
         ie_q       <= 1'b0;
         tx_ready_q <= 1'b0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         turn_cnt_q <= turn_cnt_d;
         rx_cnt_q   <= rx_cnt_d;
         pad_a_q    <= pad_a_d;
         ds_q       <= ds_d;
         sr_q       <= sr_d;
         oe_q       <= oe_d;
         ie_q       <= ie_d;
         tx_ready_q <= tx_ready_d;
         rx_valid_q <= rx_valid_d;
      end
   end

`ifdef PAD_LOOPBACK_CHECK_EN
   localparam int DCW = $clog2(SYNC_STAGES + 1);
   localparam logic [DCW-1:0] DRV_SETTLED = DCW'(SYNC_STAGES);

   // pad_a_q plus these SYNC_STAGES taps line the driven word up with its synchronized echo.
   logic [WIDTH-1:0] a_dly_q [SYNC_STAGES];
   logic [DCW-1:0]   drv_cnt_q;
   logic             err_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < SYNC_STAGES; i++) a_dly_q[i] <= '0;
         drv_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         a_dly_q[0] <= pad_a_q;
         for (int i = 1; i < SYNC_STAGES; i++) a_dly_q[i] <= a_dly_q[i-1];
         if (state_q != DRIVE) begin
            drv_cnt_q <= '0;
         end else if (drv_cnt_q != DRV_SETTLED) begin
            drv_cnt_q <= drv_cnt_q + 1'b1;
         end
         if (state_q == DRIVE && drv_cnt_q == DRV_SETTLED && sync_y != a_dly_q[SYNC_STAGES-1]) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err_mismatch = err_q;
`else
   assign err_mismatch = 1'b0;
`endif

   assign tx_ready = tx_ready_q;
   assign rx_valid = rx_valid_q;
   assign rx_data  = sync_y;
   assign pad_a    = pad_a_q;
   assign pad_oe   = oe_q;
   assign pad_ie   = ie_q;
   assign pad_ds0  = ds_q[0];
   assign pad_ds1  = ds_q[1];
   assign pad_sr   = sr_q;

endmodule
